// File: rtl/kb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kb_pkg : shared types and constants for the PS/2 keyboard receiver |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } kb_state_e;

  localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;
  localparam int         KB_EVT_W      = 10;

endpackage
`default_nettype wire

// File: rtl/kb_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kb_event_fifo : first-word-fall-through event FIFO, sticky overflow |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module kb_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  input  logic                           i_clr_ovf,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (i_clr_ovf)             r_overflow <= 1'b0;
    end
  end

  assign o_rdata    = r_mem[r_rd_ptr];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_kb_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_kb_rx_fifo : PS/2 keyboard receiver with prefix folding + FIFO  |
// | Rev 2.0                                                            |
// +--------------------------------------------------------------------+
module ps2_kb_rx_fifo
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_data,
  input  logic                              i_sclk,
  input  logic                              i_rd_en,
  input  logic                              i_clr_ovf,
  output logic                              o_done,
  output logic [7:0]                        o_frame_data,
  output logic [KB_EVT_W-1:0]               o_rd_data,
  output logic                              o_empty,
  output logic                              o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_frame_err,
  output logic                              o_overflow
);

  localparam int FLT_W = $clog2(FILTER_LEN+1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);

  logic             r_sclk_s1, r_sclk_s2;
  logic             r_data_s1, r_data_s2;
  logic             r_sclk_f, r_sclk_f_q;
  logic [FLT_W-1:0] r_flt_cnt;
  logic             w_fall;

  kb_state_e        r_state;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shreg;
  logic             r_parity;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_done;
  logic             r_frame_err;
  logic [7:0]       r_frame_data;

  logic                r_ext, r_brk;
  logic                w_push;
  logic [KB_EVT_W-1:0] w_evt;

  // Idle PS/2 lines are high, so the conditioning flops reset high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_s1  <= 1'b1;
      r_sclk_s2  <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
      r_sclk_f   <= 1'b1;
      r_sclk_f_q <= 1'b1;
      r_flt_cnt  <= '0;
    end else begin
      r_sclk_s1  <= i_sclk;
      r_sclk_s2  <= r_sclk_s1;
      r_data_s1  <= i_data;
      r_data_s2  <= r_data_s1;
      r_sclk_f_q <= r_sclk_f;
      if (r_sclk_s2 != r_sclk_f) begin
        if (r_flt_cnt == FLT_W'(FILTER_LEN-1)) begin
          r_sclk_f  <= r_sclk_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FLT_W'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_sclk_f_q && !r_sclk_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_shreg      <= '0;
      r_parity     <= 1'b0;
      r_tmo_cnt    <= '0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_data <= '0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == IDLE) begin
        r_tmo_cnt <= '0;
        if (w_fall && !r_data_s2) begin
          r_state  <= DATA;
          r_bitcnt <= '0;
        end
      end else if (w_fall) begin
        r_tmo_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shreg  <= {r_data_s2, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= r_data_s2;
            r_state  <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (r_data_s2 && (^{r_shreg, r_parity})) begin
              r_done       <= 1'b1;
              r_frame_data <= r_shreg;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end
        endcase
      end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1)) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
        r_tmo_cnt   <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Prefix bytes only arm flags; the next ordinary byte carries and clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_done) begin
      if (r_frame_data == KB_PREFIX_EXT) begin
        r_ext <= 1'b1;
      end else if (r_frame_data == KB_PREFIX_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_push = r_done && (r_frame_data != KB_PREFIX_EXT) && (r_frame_data != KB_PREFIX_BRK);
  assign w_evt  = {r_brk, r_ext, r_frame_data};

  kb_event_fifo #(
    .WIDTH (KB_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_wdata    (w_evt),
    .i_pop      (i_rd_en),
    .i_clr_ovf  (i_clr_ovf),
    .o_rdata    (o_rd_data),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  assign o_done       = r_done;
  assign o_frame_err  = r_frame_err;
  assign o_frame_data = r_frame_data;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_kb_rx_fifo : directed self-checking bench for ps2_kb_rx_fifo |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ps2_kb_rx_fifo;

  localparam int HP    = 20;
  localparam int TMO   = 500;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b1;
  logic       sclk = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       o_done;
  logic [7:0] o_frame_data;
  logic [9:0] o_rd_data;
  logic       o_empty;
  logic       o_full;
  logic [3:0] o_count;
  logic       o_frame_err;
  logic       o_overflow;

  always #5 clk = ~clk;

  ps2_kb_rx_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_sclk       (sclk),
    .i_rd_en      (rd_en),
    .i_clr_ovf    (clr_ovf),
    .o_done       (o_done),
    .o_frame_data (o_frame_data),
    .o_rd_data    (o_rd_data),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_count      (o_count),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_tot = 0;
  int   err_tot  = 0;
  logic done_empty  = 1'b0;
  logic after_empty = 1'b1;
  logic prev_done   = 1'b0;

  // Pulse counters plus a snapshot of o_empty on and just after each o_done.
  always @(negedge clk) begin
    if (o_done) begin
      done_tot++;
      done_empty = o_empty;
    end
    if (prev_done) after_empty = o_empty;
    prev_done = o_done;
    if (o_frame_err) err_tot++;
  end

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic [7:0] fd;
    logic [9:0] head;
    int         cnt;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] c, input logic bad);
    return {1'b1, (~^c) ^ bad, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      data = bits[i];
      tick(HP);
      sclk = 1'b0;
      tick(HP);
      sclk = 1'b1;
    end
    data = 1'b1;
    tick(HP);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad);
    send_bits(frame(c, bad), 11);
    tick(10);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int   d0, e0;
    logic seen;

    vecs[0] = '{8'h1C, 1'b0, 8'h1C, 10'h01C, 1, 1, 0};
    vecs[1] = '{8'hE0, 1'b0, 8'hE0, 10'h000, 0, 1, 0};
    vecs[2] = '{8'hF0, 1'b0, 8'hF0, 10'h000, 0, 1, 0};
    vecs[3] = '{8'h74, 1'b0, 8'h74, 10'h374, 1, 1, 0};
    vecs[4] = '{8'h1C, 1'b1, 8'h74, 10'h000, 0, 0, 1};
    vecs[5] = '{8'h1C, 1'b0, 8'h1C, 10'h01C, 1, 1, 0};
    vecs[6] = '{8'hE0, 1'b0, 8'hE0, 10'h000, 0, 1, 0};
    vecs[7] = '{8'h55, 1'b1, 8'hE0, 10'h000, 0, 0, 1};
    vecs[8] = '{8'h1C, 1'b0, 8'h1C, 10'h01C, 1, 1, 0};

    tick(3);
    check("rst_empty", o_empty, 1);
    check("rst_done", o_done, 0);
    check("rst_fd", o_frame_data, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_count", o_count, 0);
    check("rst_full", o_full, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_ovf", o_overflow, 0);
    rst_n = 1'b1;
    tick(20);

    for (int i = 0; i < 9; i++) begin
      d0 = done_tot;
      e0 = err_tot;
      send_frame(vecs[i].code, vecs[i].bad);
      check($sformatf("v%0d_fd", i), o_frame_data, vecs[i].fd);
      check($sformatf("v%0d_count", i), o_count, vecs[i].cnt);
      check($sformatf("v%0d_done", i), done_tot - d0, vecs[i].done);
      check($sformatf("v%0d_err", i), err_tot - e0, vecs[i].err);
      if (vecs[i].cnt > 0) begin
        check($sformatf("v%0d_head", i), o_rd_data, vecs[i].head);
        pop();
      end
      check($sformatf("v%0d_empty", i), o_empty, 1);
    end
    check("lat_empty_on_done", done_empty, 1);
    check("lat_nonempty_after", after_empty, 0);

    // Stalled frame: start plus four data bits, then a silent clock.
    d0 = done_tot;
    e0 = err_tot;
    send_bits(frame(8'h3C, 1'b0), 5);
    tick(600);
    check("tmo_err", err_tot - e0, 1);
    check("tmo_done", done_tot - d0, 0);
    send_frame(8'h2A, 1'b0);
    check("tmo_next_fd", o_frame_data, 8'h2A);
    check("tmo_next_head", o_rd_data, 10'h02A);
    check("tmo_next_count", o_count, 1);
    pop();

    d0 = done_tot;
    e0 = err_tot;
    sclk = 1'b0;
    tick(2);
    sclk = 1'b1;
    tick(50);
    check("glitch_done", done_tot - d0, 0);
    check("glitch_err", err_tot - e0, 0);
    check("glitch_count", o_count, 0);

    for (int k = 0; k < 8; k++) send_frame(8'h10 + 8'(k), 1'b0);
    check("fill_full", o_full, 1);
    check("fill_count", o_count, 8);
    check("fill_ovf", o_overflow, 0);
    send_frame(8'h18, 1'b0);
    check("ovf_set", o_overflow, 1);
    check("ovf_count", o_count, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_%0d", k), o_rd_data, 10'h010 + 10'(k));
      pop();
    end
    check("drain_empty", o_empty, 1);
    pop();
    check("pop_empty_count", o_count, 0);
    check("ovf_kept", o_overflow, 1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_clear", o_overflow, 0);

    // Full FIFO, push and pop on the same edge.
    for (int k = 0; k < 8; k++) send_frame(8'h20 + 8'(k), 1'b0);
    seen = 1'b0;
    fork
      send_frame(8'h28, 1'b0);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (o_done) begin
            seen  = 1'b1;
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
          end
        end
      end
    join
    check("simul_seen", seen, 1);
    check("simul_count", o_count, 8);
    check("simul_ovf", o_overflow, 0);
    check("simul_head", o_rd_data, 10'h021);
    send_frame(8'h29, 1'b0);
    check("simul_then_ovf", o_overflow, 1);

    // Reset in the middle of a frame.
    send_bits(frame(8'h33, 1'b0), 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_full", o_full, 0);
    check("mid_rst_ovf", o_overflow, 0);
    check("mid_rst_fd", o_frame_data, 0);
    check("mid_rst_rd_data", o_rd_data, 0);
    tick(5);
    rst_n = 1'b1;
    tick(20);
    d0 = done_tot;
    e0 = err_tot;
    send_frame(8'h1C, 1'b0);
    check("post_rst_fd", o_frame_data, 8'h1C);
    check("post_rst_head", o_rd_data, 10'h01C);
    check("post_rst_count", o_count, 1);
    check("post_rst_done", done_tot - d0, 1);
    check("post_rst_err", err_tot - e0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_kb_rx_fifo.md
Name: ps2_kb_rx_fifo

Overview:
- Second-generation PS/2 keyboard receiver. Runs entirely on the system clock; PS/2 clock and data are treated as asynchronous inputs, synchronised and glitch-filtered.
- Validates each 11-bit frame: start bit, 8 data bits LSB first, odd parity, stop bit. Recovers from stalled frames by timeout.
- Folds E0 (extended) and F0 (break) prefixes into key events and buffers the events in a parametrised FIFO for the display/controller logic.
- Keeps the raw-byte o_done / o_frame_data outputs for existing consumers.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2.
- FILTER_LEN, 4, system-clock cycles the synchronised sclk must hold a new level before the filtered sclk changes.
- TIMEOUT_CYCLES, 50000, cycles without a filtered sclk falling edge before a partial frame is aborted.

Ports:
- i_clk, input, 1, system clock, rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_data, input, 1, PS/2 data, asynchronous.
- i_sclk, input, 1, PS/2 clock, asynchronous.
- i_rd_en, input, 1, pop the head FIFO entry.
- i_clr_ovf, input, 1, clear o_overflow.
- o_done, output, 1, one-cycle pulse for each valid raw byte.
- o_frame_data, output, 8, last valid raw byte.
- o_rd_data, output, 10, head event {brk, ext, code[7:0]}; valid while !o_empty.
- o_empty, output, 1, FIFO empty.
- o_full, output, 1, FIFO full.
- o_count, output, clog2(FIFO_DEPTH+1), FIFO occupancy.
- o_frame_err, output, 1, one-cycle pulse on a parity, stop or timeout error.
- o_overflow, output, 1, sticky flag: an event was dropped.

Behaviour:
- Reset (async assert, sync release via the flops): all outputs 0 except o_empty=1. FSM enters IDLE; prefix flags, FIFO pointers and timeout counter are cleared. Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-flop synchroniser on i_sclk and on i_data.
  - Filtered sclk changes only after the synchronised value differs from it for FILTER_LEN consecutive cycles.
  - Fall = one-cycle strobe when filtered sclk goes 1 to 0; synchronised data is sampled on that cycle.
- FSM (advances only on a Fall strobe, except for timeout):
  - IDLE: data=0 moves to DATA with bitcnt=0. data=1 stays in IDLE (spurious edge, no error).
  - DATA: shift the bit into shreg[7] (right shift, LSB first); bitcnt++; after the 8th bit go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: the frame is valid when stop=1 and XOR(shreg, parity)=1. Otherwise pulse o_frame_err. Return to IDLE either way.
  - Timeout: in any non-IDLE state, if the counter reaches TIMEOUT_CYCLES with no Fall, go to IDLE and pulse o_frame_err. The counter reloads on every Fall.
- Timing: a valid frame is detected on cycle N (the stop-bit Fall). On N+1, o_done=1, o_frame_data=shreg, and the decoder acts. On N+2, the event is visible at the FIFO head (o_empty=0) if the FIFO was empty.
- Decoder (acts on each valid byte):
  - 0xE0 sets ext; 0xF0 sets brk; neither is pushed.
  - Any other byte pushes {brk, ext, byte}, then clears both flags.
  - Any frame error clears both flags.
- FIFO:
  - First-word-fall-through; o_rd_data is the head entry, registered storage.
  - Pop when i_rd_en && !o_empty; i_rd_en while empty is ignored.
  - Push when full and no pop: drop the new event, set o_overflow.
  - Push and pop in the same cycle: both take effect, count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_full = (count==FIFO_DEPTH); o_empty = (count==0).
- o_overflow: cleared by i_clr_ovf; a same-cycle drop wins over i_clr_ovf.

Decomposition:
- Package kb_pkg holds:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Constants KB_PREFIX_EXT=8'hE0 and KB_PREFIX_BRK=8'hF0.
  - Event width KB_EVT_W=10.
- Sub-module kb_event_fifo (parametrised by width and depth) holds storage, pointers, count and flags.
- Synchroniser, filter, FSM and decoder stay in the top module.

Test Plan (each PS/2 half-period is 2000 clk; FIFO_DEPTH=8; TIMEOUT_CYCLES=50000):
- Frame 0x1C, parity 0, stop 1 -> one o_done pulse; o_frame_data=0x1C; o_rd_data=0x01C; o_count=1; o_frame_err never asserts.
- Frames E0, F0, 74 -> o_done pulses 3 times; exactly one event 0x374; o_frame_data=0x74.
- Frame 0x1C with parity 1 -> o_frame_err pulses once; no push; o_frame_data keeps its prior value. A following 0x1C with correct parity is accepted.
- Start bit plus 4 data bits, then sclk held high for 60000 cycles -> o_frame_err pulses once. A following 0x2A (parity 0) gives o_frame_data=0x2A and event 0x02A.
- Send 9 distinct codes (0x10-0x18) with no reads -> o_full=1 after 8; o_overflow=1; 8 pops return 0x010-0x017 in order. i_clr_ovf then clears o_overflow.
- 2-cycle low glitch on i_sclk while IDLE -> no state change, no outputs. Assert i_rst_n=0 mid-frame -> all outputs 0 immediately, o_empty=1. The next full frame is received correctly.
